fp_norm_pipe: RTL and testbench

FP_NORM_PIPE -- requirements
Module: fp_norm_pipe

---
 rtl/fp_norm_pipe.sv | 263 ++++++++++++++++++++++++++
 tb/tb_fp_norm_pipe.sv | 289 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fp_norm_pipe.sv
// ---------------------------------------------------------------------------
// fp_norm_pipe
//
// Two-stage elastic normalizer for the raw result of a floating-point
// add/subtract. Stage 1 registers the incoming operand together with the
// leading-zero count k. Stage 2 registers the shifted mantissa, adjusted
// exponent and status flags. Latency is two cycles when nothing stalls.
//
// Ports
//   clk        : single clock, rising edge
//   rst_n      : synchronous active-low reset
//   in_valid   : upstream data valid
//   in_ready   : block accepts data this cycle
//   sign_in    : result sign (passed through unchanged)
//   mant_in    : raw sum/difference, bit MAN_W = hidden bit, MAN_W+1 = carry
//   exp_in     : pre-normalize exponent
//   grs_in     : guard/round/sticky bits
//   out_valid  : result valid
//   out_ready  : downstream accepts
//   sign_out   : result sign
//   mant_out   : normalized stored fraction (hidden bit removed)
//   exp_out    : normalized exponent
//   grs_out    : normalized guard/round/sticky
//   ovf/uf/zero: status flags, meaningful while out_valid is high
//
// Handshake: a transfer occurs on a rising edge where valid && ready are
// both high. Once valid is raised it stays high, with stable payload,
// until the transfer happens; ready may toggle freely and never depends
// on valid.
// ---------------------------------------------------------------------------
module fp_norm_pipe #(
    parameter int EXP_W = 8,
    parameter int MAN_W = 23
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic               sign_in,
    input  logic [MAN_W+1:0]   mant_in,
    input  logic [EXP_W-1:0]   exp_in,
    input  logic [2:0]         grs_in,
    output logic               out_valid,
    input  logic               out_ready,
    output logic               sign_out,
    output logic [MAN_W-1:0]   mant_out,
    output logic [EXP_W-1:0]   exp_out,
    output logic [2:0]         grs_out,
    output logic               ovf,
    output logic               uf,
    output logic               zero
);

    // {mant_in, grs_in} is the full working vector; LW is the part below
    // the carry bit, which is where leading zeros are counted.
    localparam int VW = MAN_W + 5;
    localparam int LW = MAN_W + 4;
    localparam int KW = $clog2(LW + 1);
    localparam int CW = ((KW > EXP_W) ? KW : EXP_W) + 1;

    localparam logic [EXP_W-1:0] EXP_ONES = '1;
    // Largest finite exponent: a carry from here lands on all-ones.
    localparam logic [EXP_W-1:0] EXP_TOP  = {{(EXP_W-1){1'b1}}, 1'b0};

    // -----------------------------------------------------------------------
    // Pipeline control
    // -----------------------------------------------------------------------
    logic s1_valid_q, s1_valid_d;
    logic s2_valid_q, s2_valid_d;
    logic in_fire, out_fire, s1_adv;

    // Stage 1 moves forward whenever stage 2 is empty or being drained.
    assign s1_adv    = s1_valid_q && (!s2_valid_q || out_ready);
    assign in_ready  = rst_n && (!s1_valid_q || !s2_valid_q || out_ready);
    assign out_valid = rst_n && s2_valid_q;
    assign in_fire   = in_valid && in_ready;
    assign out_fire  = out_valid && out_ready;

    always_comb begin
        s1_valid_d = s1_valid_q;
        if (in_fire) begin
            s1_valid_d = 1'b1;
        end else if (s1_adv) begin
            s1_valid_d = 1'b0;
        end
    end

    always_comb begin
        s2_valid_d = s2_valid_q;
        if (s1_adv) begin
            s2_valid_d = 1'b1;
        end else if (out_fire) begin
            s2_valid_d = 1'b0;
        end
    end

    // -----------------------------------------------------------------------
    // Stage 1: leading-zero count below the carry bit
    // -----------------------------------------------------------------------
    logic [LW-1:0] low_vec;
    logic [KW-1:0] lzc;
    logic          lz_found;

    // Counts zeros from the hidden-bit position downward through the
    // guard/round/sticky bits. A normal operand yields 0, so the same
    // shift path serves both the normal and the leading-zero cases.
    always_comb begin
        low_vec  = {mant_in[MAN_W:0], grs_in};
        lzc      = KW'(LW);
        lz_found = 1'b0;
        for (int i = LW - 1; i >= 0; i--) begin
            if (!lz_found && low_vec[i]) begin
                lzc      = KW'(LW - 1 - i);
                lz_found = 1'b1;
            end
        end
    end

    logic             s1_sign_q, s1_sign_d;
    logic [MAN_W+1:0] s1_mant_q, s1_mant_d;
    logic [EXP_W-1:0] s1_exp_q,  s1_exp_d;
    logic [2:0]       s1_grs_q,  s1_grs_d;
    logic [KW-1:0]    s1_k_q,    s1_k_d;

    always_comb begin
        s1_sign_d = s1_sign_q;
        s1_mant_d = s1_mant_q;
        s1_exp_d  = s1_exp_q;
        s1_grs_d  = s1_grs_q;
        s1_k_d    = s1_k_q;
        if (in_fire) begin
            s1_sign_d = sign_in;
            s1_mant_d = mant_in;
            s1_exp_d  = exp_in;
            s1_grs_d  = grs_in;
            s1_k_d    = lzc;
        end
    end

    // -----------------------------------------------------------------------
    // Stage 2: shift, exponent adjust and exception classification
    // -----------------------------------------------------------------------
    logic [MAN_W+2:0] shifted;
    logic [MAN_W-1:0] res_mant;
    logic [EXP_W-1:0] res_exp;
    logic [2:0]       res_grs;
    logic             res_ovf, res_uf, res_zero;

    // Priority: all-ones exponent (inf/NaN) first, then exact zero, then
    // the carry path (which may overflow), then left normalization (which
    // may underflow). The k >= exp comparison is done in a widened domain
    // so neither operand can wrap.
    always_comb begin
        res_mant = '0;
        res_exp  = '0;
        res_grs  = '0;
        res_ovf  = 1'b0;
        res_uf   = 1'b0;
        res_zero = 1'b0;
        shifted  = (MAN_W + 3)'({s1_mant_q, s1_grs_q} << s1_k_q);

        if (s1_exp_q == EXP_ONES) begin
            res_mant = s1_mant_q[MAN_W-1:0];
            res_exp  = s1_exp_q;
            res_grs  = s1_grs_q;
        end else if ((s1_mant_q == '0) && (s1_grs_q == '0)) begin
            res_zero = 1'b1;
        end else if (s1_mant_q[MAN_W+1]) begin
            if (s1_exp_q == EXP_TOP) begin
                res_ovf = 1'b1;
                res_exp = EXP_ONES;
            end else begin
                // The bit shifted out becomes the new guard; old guard
                // becomes round; old round and sticky fold into sticky.
                res_mant = s1_mant_q[MAN_W:1];
                res_grs  = {s1_mant_q[0], s1_grs_q[2], s1_grs_q[1] | s1_grs_q[0]};
                res_exp  = s1_exp_q + 1'b1;
            end
        end else if (CW'(s1_k_q) >= CW'(s1_exp_q)) begin
            res_uf = 1'b1;
        end else begin
            // k < exp here, so k fits in EXP_W bits and the subtraction
            // cannot wrap.
            res_mant = shifted[MAN_W+2:3];
            res_grs  = shifted[2:0];
            res_exp  = s1_exp_q - EXP_W'(s1_k_q);
        end
    end

    logic             s2_sign_q, s2_sign_d;
    logic [MAN_W-1:0] s2_mant_q, s2_mant_d;
    logic [EXP_W-1:0] s2_exp_q,  s2_exp_d;
    logic [2:0]       s2_grs_q,  s2_grs_d;
    logic             s2_ovf_q,  s2_ovf_d;
    logic             s2_uf_q,   s2_uf_d;
    logic             s2_zero_q, s2_zero_d;

    // Stage 2 only loads on advance, so its outputs hold while stalled.
    always_comb begin
        s2_sign_d = s2_sign_q;
        s2_mant_d = s2_mant_q;
        s2_exp_d  = s2_exp_q;
        s2_grs_d  = s2_grs_q;
        s2_ovf_d  = s2_ovf_q;
        s2_uf_d   = s2_uf_q;
        s2_zero_d = s2_zero_q;
        if (s1_adv) begin
            s2_sign_d = s1_sign_q;
            s2_mant_d = res_mant;
            s2_exp_d  = res_exp;
            s2_grs_d  = res_grs;
            s2_ovf_d  = res_ovf;
            s2_uf_d   = res_uf;
            s2_zero_d = res_zero;
        end
    end

    // -----------------------------------------------------------------------
    // State registers
    // -----------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            s1_valid_q <= 1'b0;
            s1_sign_q  <= 1'b0;
            s1_mant_q  <= '0;
            s1_exp_q   <= '0;
            s1_grs_q   <= '0;
            s1_k_q     <= '0;
            s2_valid_q <= 1'b0;
            s2_sign_q  <= 1'b0;
            s2_mant_q  <= '0;
            s2_exp_q   <= '0;
            s2_grs_q   <= '0;
            s2_ovf_q   <= 1'b0;
            s2_uf_q    <= 1'b0;
            s2_zero_q  <= 1'b0;
        end else begin
            s1_valid_q <= s1_valid_d;
            s1_sign_q  <= s1_sign_d;
            s1_mant_q  <= s1_mant_d;
            s1_exp_q   <= s1_exp_d;
            s1_grs_q   <= s1_grs_d;
            s1_k_q     <= s1_k_d;
            s2_valid_q <= s2_valid_d;
            s2_sign_q  <= s2_sign_d;
            s2_mant_q  <= s2_mant_d;
            s2_exp_q   <= s2_exp_d;
            s2_grs_q   <= s2_grs_d;
            s2_ovf_q   <= s2_ovf_d;
            s2_uf_q    <= s2_uf_d;
            s2_zero_q  <= s2_zero_d;
        end
    end

    assign sign_out = s2_sign_q;
    assign mant_out = s2_mant_q;
    assign exp_out  = s2_exp_q;
    assign grs_out  = s2_grs_q;
    assign ovf      = s2_ovf_q;
    assign uf       = s2_uf_q;
    assign zero     = s2_zero_q;

endmodule

// File: tb/tb_fp_norm_pipe.sv
// Bench for fp_norm_pipe with default parameters (EXP_W=8, MAN_W=23).
// Result bus layout: {sign, mant[22:0], exp[7:0], grs[2:0], ovf, uf, zero}.
module tb_fp_norm_pipe;

    localparam int W = 38;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic        sign_in;
    logic [24:0] mant_in;
    logic [7:0]  exp_in;
    logic [2:0]  grs_in;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic        sign_out;
    logic [22:0] mant_out;
    logic [7:0]  exp_out;
    logic [2:0]  grs_out;
    logic        ovf, uf, zero;

    fp_norm_pipe #(.EXP_W(8), .MAN_W(23)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .sign_in  (sign_in),
        .mant_in  (mant_in),
        .exp_in   (exp_in),
        .grs_in   (grs_in),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .sign_out (sign_out),
        .mant_out (mant_out),
        .exp_out  (exp_out),
        .grs_out  (grs_out),
        .ovf      (ovf),
        .uf       (uf),
        .zero     (zero)
    );

    logic [W-1:0] out_bus;
    assign out_bus = {sign_out, mant_out, exp_out, grs_out, ovf, uf, zero};

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string tag, input logic [39:0] got, input logic [39:0] want);
        n_tests++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, want);
        end
    endtask

    // ---------------- reference model ----------------
    // Works on the numeric value of {mant, grs} as an integer: the hidden
    // bit sits at weight 2^26, the carry at 2^27.
    function automatic logic [W-1:0] model(input logic s, input logic [24:0] m,
                                           input logic [7:0] e, input logic [2:0] g);
        longint full, sh;
        int k;
        logic [22:0] mo;
        logic [7:0]  eo;
        logic [2:0]  go;
        logic f_ov, f_uf, f_z;
        full = longint'(m) * 8 + longint'(g);
        mo = '0; eo = '0; go = '0; f_ov = 1'b0; f_uf = 1'b0; f_z = 1'b0;
        if (e == 8'hFF) begin
            mo = 23'(longint'(m) % (longint'(1) << 23));
            eo = e;
            go = g;
        end else if (full == 0) begin
            f_z = 1'b1;
        end else if (longint'(m) >= (longint'(1) << 24)) begin
            if (e == 8'hFE) begin
                f_ov = 1'b1;
                eo   = 8'hFF;
            end else begin
                mo = 23'((longint'(m) / 2) % (longint'(1) << 23));
                go = {m[0], g[2], g[1] | g[0]};
                eo = 8'(int'(e) + 1);
            end
        end else begin
            k = 0;
            while ((full << k) < (longint'(1) << 26)) k++;
            if (k >= int'(e)) begin
                f_uf = 1'b1;
            end else begin
                sh = full << k;
                mo = 23'((sh / 8) % (longint'(1) << 23));
                go = 3'(sh % 8);
                eo = 8'(int'(e) - k);
            end
        end
        return {s, mo, eo, go, f_ov, f_uf, f_z};
    endfunction

    // ---------------- out_ready driver ----------------
    logic or_rand  = 1'b0;
    logic or_force = 1'b1;
    always @(posedge clk) begin
        #1;
        if (or_rand) out_ready = ($urandom_range(0, 3) != 0);
        else         out_ready = or_force;
    end

    // ---------------- scoreboard / monitor ----------------
    logic [W-1:0] exp_q[$];
    logic [W-1:0] held_bus;
    logic         held_v = 1'b0;

    always @(negedge clk) begin
        if (!rst_n) begin
            held_v = 1'b0;
        end else begin
            if (held_v) check("hold", 40'({out_valid, out_bus}), 40'({1'b1, held_bus}));
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) check("spurious_out", 40'(out_valid), 40'(0));
                else                   check("data", 40'(out_bus), 40'(exp_q.pop_front()));
                held_v = 1'b0;
            end else if (out_valid) begin
                held_v   = 1'b1;
                held_bus = out_bus;
            end else begin
                held_v = 1'b0;
            end
            if (in_valid && in_ready) exp_q.push_back(model(sign_in, mant_in, exp_in, grs_in));
        end
    end

    // ---------------- driver tasks ----------------
    // Called just after a rising edge; returns just after the accepting edge.
    task automatic send(input logic s, input logic [24:0] m, input logic [7:0] e, input logic [2:0] g);
        int waitc = 0;
        in_valid = 1'b1;
        sign_in  = s;
        mant_in  = m;
        exp_in   = e;
        grs_in   = g;
        @(negedge clk);
        while (!in_ready && waitc < 200) begin
            @(negedge clk);
            waitc++;
        end
        if (!in_ready) check("send_timeout", 40'(in_ready), 40'(1));
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic drain(input string tag);
        int waitc = 0;
        while (exp_q.size() != 0 && waitc < 300) begin
            @(posedge clk);
            #1;
            waitc++;
        end
        check(tag, 40'(exp_q.size()), 40'(0));
    endtask

    // Single transaction on an idle pipe with out_ready high: checks
    // the two-cycle latency and the result against a fixed value.
    task automatic directed(input string tag, input logic s, input logic [24:0] m,
                            input logic [7:0] e, input logic [2:0] g, input logic [W-1:0] want);
        int cyc = 1;
        send(s, m, e, g);
        @(negedge clk);
        while (!out_valid && cyc < 20) begin
            @(negedge clk);
            cyc++;
        end
        check({tag, "_latency"}, 40'(cyc), 40'(2));
        check(tag, 40'(out_bus), 40'(want));
        @(posedge clk);
        #1;
    endtask

    // ---------------- main sequence ----------------
    logic        rs;
    logic [24:0] rm;
    logic [7:0]  re;
    logic [2:0]  rg;

    initial begin
        rst_n = 1'b0; in_valid = 1'b0; sign_in = 1'b0;
        mant_in = '0; exp_in = '0; grs_in = '0;

        repeat (3) @(negedge clk);
        check("rst_out_valid", 40'(out_valid), 40'(0));
        check("rst_in_ready", 40'(in_ready), 40'(0));
        @(posedge clk); #1 rst_n = 1'b1;
        @(negedge clk);
        check("post_rst_in_ready", 40'(in_ready), 40'(1));
        @(posedge clk); #1;

        // Directed corner cases.
        directed("carry", 1'b0, 25'h1000001, 8'h80, 3'b100, {1'b0, 23'h0, 8'h81, 3'b110, 3'b000});
        directed("lshift", 1'b0, 25'h0100000, 8'h80, 3'b101, {1'b0, 23'h000005, 8'h7D, 3'b000, 3'b000});
        directed("underflow", 1'b0, 25'h0000400, 8'h05, 3'b000, {1'b0, 23'h0, 8'h00, 3'b000, 3'b010});
        directed("zero", 1'b1, 25'h0, 8'h40, 3'b000, {1'b1, 23'h0, 8'h00, 3'b000, 3'b001});
        directed("overflow", 1'b0, 25'h1000000, 8'hFE, 3'b000, {1'b0, 23'h0, 8'hFF, 3'b000, 3'b100});
        directed("special", 1'b0, 25'h1ABCDEF, 8'hFF, 3'b011, {1'b0, 23'h2BCDEF, 8'hFF, 3'b011, 3'b000});
        directed("normal", 1'b1, 25'h0812345, 8'h01, 3'b010, {1'b1, 23'h012345, 8'h01, 3'b010, 3'b000});
        directed("sticky_only", 1'b0, 25'h0, 8'h40, 3'b001, {1'b0, 23'h0, 8'h26, 3'b000, 3'b000});

        // Backpressure: three back-to-back inputs against a stalled output.
        or_force = 1'b0;
        @(posedge clk); #1;
        in_valid = 1'b1; sign_in = 1'b0; mant_in = 25'h0900000; exp_in = 8'h10; grs_in = 3'b000;
        @(negedge clk); check("bp_rdy0", 40'(in_ready), 40'(1));
        @(posedge clk); #1;
        sign_in = 1'b1; mant_in = 25'h1800003; exp_in = 8'h20; grs_in = 3'b111;
        @(negedge clk); check("bp_rdy1", 40'(in_ready), 40'(1));
        @(posedge clk); #1;
        sign_in = 1'b0; mant_in = 25'h0001234; exp_in = 8'h90; grs_in = 3'b010;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("bp_full_rdy", 40'(in_ready), 40'(0));
            check("bp_out_valid", 40'(out_valid), 40'(1));
            if (i == 4) or_force = 1'b1;
            @(posedge clk); #1;
        end
        send(1'b0, 25'h0001234, 8'h90, 3'b010);
        drain("bp_drain");

        // Randomized traffic with random backpressure.
        or_rand = 1'b1;
        for (int n = 0; n < 1500; n++) begin
            rs = 1'($urandom_range(0, 1));
            rm = 25'($urandom);
            re = 8'($urandom_range(1, 254));
            rg = 3'($urandom_range(0, 7));
            case ($urandom_range(0, 7))
                0: rm[24] = 1'b1;
                1: rm[24:23] = 2'b01;
                2: rm = rm >> $urandom_range(2, 24);
                3: rm = '0;
                4: re = 8'hFF;
                5: begin re = 8'($urandom_range(0, 30)); rm = rm >> $urandom_range(2, 24); end
                6: begin rm[24] = 1'b1; re = ($urandom_range(0, 1) != 0) ? 8'hFE : 8'hFD; end
                default: begin rm = '0; rg = '0; end
            endcase
            send(rs, rm, re, rg);
            repeat ($urandom_range(0, 1)) begin @(posedge clk); #1; end
        end
        drain("rand_drain");

        // Reset with both stages occupied.
        or_rand  = 1'b0;
        or_force = 1'b0;
        @(posedge clk); #1;
        send(1'b0, 25'h0812345, 8'h40, 3'b000);
        send(1'b1, 25'h1000001, 8'h41, 3'b100);
        rst_n = 1'b0;
        exp_q.delete();
        @(negedge clk);
        check("mid_rst_out_valid", 40'(out_valid), 40'(0));
        check("mid_rst_in_ready", 40'(in_ready), 40'(0));
        or_force = 1'b1;
        @(posedge clk); #1 rst_n = 1'b1;
        @(negedge clk);
        check("rel_out_valid", 40'(out_valid), 40'(0));
        check("rel_in_ready", 40'(in_ready), 40'(1));
        repeat (6) begin
            @(negedge clk);
            check("no_stale", 40'(out_valid), 40'(0));
        end
        @(posedge clk); #1;
        directed("after_reset", 1'b0, 25'h0400000, 8'h30, 3'b000, {1'b0, 23'h0, 8'h2F, 3'b000, 3'b000});
        drain("final_drain");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        n_fail++;
        $display("FAIL watchdog: simulation time limit reached");
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
